// File: rtl/ir_pkg.sv
// Shared constants, types and FSM states for the cabinet-IR convolver.
package ir_pkg;

    localparam int IR_TAPS   = 256;
    localparam int IR_DATA_W = 16;
    localparam int IR_COEF_W = 16;
    localparam int IR_FRAC   = 15;
    localparam int IR_ACC_W  = 40;

    typedef logic signed [IR_COEF_W-1:0] coef_t;
    typedef logic signed [IR_ACC_W-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        OUT
    } conv_state_t;

endpackage

// File: rtl/ir_history_ram.sv
// Sample history ring buffer: one write port, one synchronous read port.
// Plain memory with no reset so it maps onto block RAM; the parent zeroes it
// with a write sweep after reset.
module ir_history_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port, used both for new samples and the clear sweep
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read: data for an address appears one clock later
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ir_convolver.sv
// Time-multiplexed FIR engine for cabinet impulse responses.
// One MAC per clock: y[n] = sum_k w[k]*x[n-k], rounded and saturated to DATA_W.
module ir_convolver
    import ir_pkg::*;
#(
    parameter int TAPS   = IR_TAPS,
    parameter int DATA_W = IR_DATA_W,
    parameter int COEF_W = IR_COEF_W,
    parameter int FRAC   = IR_FRAC,
    parameter int ACC_W  = IR_ACC_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TAPS-1:0][COEF_W-1:0]   weights,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      in_sample,
    output logic                          out_valid,
    output logic signed [DATA_W-1:0]      out_sample
);

    localparam int AW = $clog2(TAPS);
    localparam int PW = DATA_W + COEF_W;
    localparam logic [AW-1:0]            LAST_TAP = AW'(TAPS - 1);
    localparam logic signed [ACC_W-1:0]  HALF     = ACC_W'(64'd1 << (FRAC - 1));
    localparam logic signed [ACC_W-1:0]  SAT_MAX  = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN  = ~SAT_MAX;

    conv_state_t state, state_nx;

    logic                     accept;
    logic                     clearing;
    logic                     finish;
    logic                     v1;
    logic                     v2;
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            tap;
    logic [AW-1:0]            clr_addr;
    logic                     ram_we;
    logic [AW-1:0]            ram_waddr;
    logic [AW-1:0]            ram_raddr;
    logic [DATA_W-1:0]        ram_wdata;
    logic [DATA_W-1:0]        ram_rdata;
    logic signed [COEF_W-1:0] w_q;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_rnd;
    logic signed [ACC_W-1:0]  acc_shr;
    logic signed [DATA_W-1:0] y_sat;

    // The OUT cycle doubles as an accept slot so back-to-back samples lose no cycle.
    // wr_ptr has already advanced on entry to OUT, so writes there land in the new slot.
    assign in_ready  = !clearing && ((state == IDLE) || (state == OUT));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == OUT);
    assign finish    = (state == DRAIN) && (state_nx == OUT);

    assign ram_we    = clearing || accept;
    assign ram_waddr = clearing ? clr_addr : wr_ptr;
    assign ram_wdata = clearing ? '0 : in_sample;
    assign ram_raddr = wr_ptr - tap;

    ir_history_ram #(
        .DEPTH (TAPS),
        .WIDTH (DATA_W),
        .AW    (AW)
    ) u_hist (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Zero the whole history after every reset, one entry per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clearing <= 1'b1;
            clr_addr <= '0;
        end else if (clearing) begin
            clr_addr <= clr_addr + AW'(1);
            if (clr_addr == LAST_TAP) begin
                clearing <= 1'b0;
            end
        end
    end

    // Next-state: walk all taps, wait for the multiply/accumulate pipe to empty, present
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = MAC;
            MAC:     if (tap == LAST_TAP) state_nx = DRAIN;
            DRAIN:   if (!v1 && !v2) state_nx = OUT;
            OUT:     state_nx = accept ? MAC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register, tap counter and write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            tap    <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                tap <= '0;
            end else if (state == MAC) begin
                tap <= tap + AW'(1);
            end
            if (finish) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

    // Coefficient is registered alongside the RAM read so both reach the multiplier together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            w_q  <= '0;
            prod <= '0;
        end else begin
            v1   <= (state == MAC);
            v2   <= v1;
            w_q  <= weights[tap];
            prod <= $signed(ram_rdata) * w_q;
        end
    end

    // Accumulator is cleared on accept and sums one sign-extended product per valid beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= '0;
        end else if (v2) begin
            acc <= acc + ACC_W'(prod);
        end
    end

    // Round half toward +inf, drop fraction bits, clamp to the sample range
    always_comb begin
        acc_rnd = acc + HALF;
        acc_shr = acc_rnd >>> FRAC;
        y_sat   = acc_shr[DATA_W-1:0];
        if (acc_shr > SAT_MAX) begin
            y_sat = SAT_MAX[DATA_W-1:0];
        end else if (acc_shr < SAT_MIN) begin
            y_sat = SAT_MIN[DATA_W-1:0];
        end
    end

    // Result register holds the last output until the next one is ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sample <= '0;
        end else if (finish) begin
            out_sample <= y_sat;
        end
    end

endmodule

// File: tb/tb_ir_convolver.sv
// Scoreboard bench for ir_convolver, run at a reduced tap count to keep runtime short.
module tb_ir_convolver;

    localparam int TAPS   = 32;
    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int LAT    = TAPS + 4;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [TAPS-1:0][COEF_W-1:0] weights;
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_W-1:0]           in_sample;
    logic                        out_valid;
    logic [DATA_W-1:0]           out_sample;

    ir_convolver #(
        .TAPS   (TAPS),
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC   (15),
        .ACC_W  (40)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .weights    (weights),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .out_valid  (out_valid),
        .out_sample (out_sample)
    );

    typedef struct {
        logic [15:0] val;
        int          acc_cyc;
        string       tag;
    } exp_t;

    exp_t               exp_q[$];
    exp_t               mon_e;
    int                 total = 0;
    int                 bad = 0;
    int                 outs_seen = 0;
    int                 cyc = 0;
    logic signed [15:0] hist [TAPS];
    int                 mptr = 0;

    always #5 clk = ~clk;

    // Free-running edge counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < TAPS; i++) hist[i] = '0;
        mptr = 0;
    endfunction

    // Reference FIR: writes x into the model history and returns the expected output
    function automatic logic [15:0] modelPush(input logic [15:0] x);
        longint acc;
        longint y;
        hist[mptr] = x;
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            acc += longint'($signed(weights[k])) * longint'(hist[(mptr - k + TAPS) % TAPS]);
        end
        mptr = (mptr + 1) % TAPS;
        y = (acc + 64'sd16384) >>> 15;
        if (y > 32767) y = 32767;
        else if (y < -32768) y = -32768;
        return 16'(y);
    endfunction

    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] want,
                                 input bit use_model, input bit expect_out, input string tag);
        int          waited = 0;
        logic [15:0] m;
        @(negedge clk);
        while (!in_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_ready_timeout: in_ready=%b after %0d cycles, required 1", tag, in_ready, waited);
            return;
        end
        in_valid  = 1'b1;
        in_sample = x;
        m = modelPush(x);
        if (expect_out) exp_q.push_back('{use_model ? m : want, cyc + 1, tag});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() != 0 && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic loadImpulseBank();
        weights[0] = 16'h0519;
        weights[1] = 16'h0B13;
        weights[2] = 16'h0E31;
        weights[3] = 16'h1021;
        for (int i = 4; i < TAPS; i++) begin
            if (i % 2 == 1) weights[i] = 16'(-(3840 - i * 64));
            else            weights[i] = 16'(3840 - i * 64);
        end
    endtask

    // Monitor: every out_valid pops one expectation and checks value and latency
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            outs_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_out: got out_valid with out_sample=%h, required no output", out_sample);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput(mon_e.tag, 32'(out_sample), 32'(mon_e.val));
                checkOutput({mon_e.tag, "_latency"}, 32'(cyc + 1 - mon_e.acc_cyc), 32'(LAT));
            end
        end
    end

    // Watchdog so a stuck design still produces a verdict
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc_cnt;
        int low_cnt;
        int saved;

        in_valid  = 1'b0;
        in_sample = '0;
        rst_n     = 1'b0;
        modelReset();
        loadImpulseBank();

        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_sample", 32'(out_sample), 32'd0);
        rst_n = 1'b1;

        $display("[TB] impulse response");
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus((i == 0) ? 16'h7FFF : 16'h0000, weights[i], 1'b0, 1'b1, "impulse");
        end
        waitDrain();

        $display("[TB] saturation");
        for (int i = 0; i < TAPS; i++) weights[i] = 16'h4000;
        for (int n = 0; n < TAPS; n++) begin
            applyStimulus(16'h4000, sat16((n + 1) * 8192), 1'b0, 1'b1, "sat_pos");
        end
        for (int n = 0; n < TAPS; n++) begin
            applyStimulus(16'hC000, sat16((TAPS - 2 - 2 * n) * 8192), 1'b0, 1'b1, "sat_neg");
        end
        waitDrain();

        $display("[TB] rounding");
        for (int i = 0; i < TAPS; i++) weights[i] = 16'h0000;
        weights[0] = 16'h0001;
        applyStimulus(16'h4000, 16'h0001, 1'b0, 1'b1, "round_half_up");
        applyStimulus(16'h3FFF, 16'h0000, 1'b0, 1'b1, "round_below_half");
        applyStimulus(16'hC000, 16'h0000, 1'b0, 1'b1, "round_neg_half");
        applyStimulus(16'hBFFF, 16'hFFFF, 1'b0, 1'b1, "round_neg_below");
        waitDrain();

        $display("[TB] handshake with in_valid held high");
        acc_cnt   = 0;
        low_cnt   = 0;
        in_sample = 16'h4000;
        in_valid  = 1'b1;
        for (int i = 0; i < 3 * LAT; i++) begin
            if (i > 0) @(negedge clk);
            if (in_ready) begin
                acc_cnt++;
                void'(modelPush(16'h4000));
                exp_q.push_back('{16'h0001, cyc + 1, "hold"});
            end else begin
                low_cnt++;
            end
        end
        in_valid = 1'b0;
        checkOutput("hold_accepts", 32'(acc_cnt), 32'd3);
        checkOutput("hold_ready_low", 32'(low_cnt), 32'(3 * (LAT - 1)));
        waitDrain();

        $display("[TB] reset during MAC");
        loadImpulseBank();
        applyStimulus(16'h1234, 16'h0000, 1'b0, 1'b0, "abort");
        repeat (TAPS / 2) @(negedge clk);
        rst_n = 1'b0;
        saved = outs_seen;
        repeat (2) @(negedge clk);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_out_sample", 32'(out_sample), 32'd0);
        rst_n = 1'b1;
        modelReset();
        repeat (LAT + TAPS) @(negedge clk);
        checkOutput("abort_no_output", 32'(outs_seen), 32'(saved));
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus((i == 0) ? 16'h7FFF : 16'h0000, weights[i], 1'b0, 1'b1, "impulse_after_reset");
        end
        waitDrain();

        $display("[TB] random weights and samples against reference");
        for (int i = 0; i < TAPS; i++) weights[i] = 16'($urandom);
        for (int n = 0; n < 600; n++) begin
            applyStimulus((n % 50 == 7) ? 16'h8000 : 16'($urandom), 16'h0000, 1'b1, 1'b1, "random");
        end
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
